// File: rtl/kernel_mem_loader.sv
// Streams complex elements into 4x4 kernels and writes them to kernel
// memory as two 8-element half-blocks per kernel.
module kernel_mem_loader #(
   parameter int KERNEL_MEM_DEPTH_BITS = 9
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [KERNEL_MEM_DEPTH_BITS-1:0] base_addr,
   input  logic [KERNEL_MEM_DEPTH_BITS-1:0] num_kernels,
   input  logic                             in_valid,
   input  logic [21:0]                      in_data,
   output logic                             in_ready,
   output logic                             mem_we,
   output logic [KERNEL_MEM_DEPTH_BITS-1:0] mem_write_address,
   output logic                             mem_select,
   output logic [175:0]                     mem_in,
   output logic                             busy,
   output logic                             done
);

   localparam int D = KERNEL_MEM_DEPTH_BITS;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [D-1:0] ONE = D'(1);

   logic [1:0]   state_q, state_d;
   logic [2:0]   slot_q, slot_d;
   logic         half_q, half_d;
   logic [D-1:0] kcnt_q, kcnt_d;
   logic [D-1:0] base_q, base_d;
   logic [D-1:0] nk_q, nk_d;
   logic [21:0]  slots_q [0:6];
   logic [21:0]  slots_d [0:6];
   logic [D-1:0] addr_q, addr_d;
   logic         sel_q, sel_d;
   logic [175:0] data_q, data_d;

   logic xfer;

   assign xfer = in_valid && (state_q == S_FILL);

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      half_d  = half_q;
      kcnt_d  = kcnt_q;
      base_d  = base_q;
      nk_d    = nk_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      data_d  = data_q;
      for (int k = 0; k < 7; k++) begin
         slots_d[k] = slots_q[k];
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               nk_d    = num_kernels;
               slot_d  = 3'd0;
               half_d  = 1'b0;
               kcnt_d  = '0;
               state_d = (num_kernels == '0) ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            if (xfer) begin
               slot_d = slot_q + 3'd1;
               // The 8th element bypasses the slot store straight into the
               // output register so the write can fire next cycle.
               if (slot_q == 3'd7) begin
                  for (int k = 0; k < 7; k++) begin
                     data_d[22*k +: 22] = slots_q[k];
                  end
                  data_d[175:154] = in_data;
                  addr_d  = base_q + kcnt_q;
                  sel_d   = half_q;
                  state_d = S_WRITE;
               end else begin
                  for (int k = 0; k < 7; k++) begin
                     if (slot_q == 3'(k)) begin
                        slots_d[k] = in_data;
                     end
                  end
               end
            end
         end
         S_WRITE: begin
            if (!half_q) begin
               half_d  = 1'b1;
               state_d = S_FILL;
            end else if (kcnt_q == nk_q - ONE) begin
               state_d = S_DONE;
            end else begin
               half_d  = 1'b0;
               kcnt_d  = kcnt_q + ONE;
               state_d = S_FILL;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         slot_q  <= 3'd0;
         half_q  <= 1'b0;
         kcnt_q  <= '0;
         base_q  <= '0;
         nk_q    <= '0;
         addr_q  <= '0;
         sel_q   <= 1'b0;
         data_q  <= '0;
         for (int k = 0; k < 7; k++) begin
            slots_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         half_q  <= half_d;
         kcnt_q  <= kcnt_d;
         base_q  <= base_d;
         nk_q    <= nk_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         for (int k = 0; k < 7; k++) begin
            slots_q[k] <= slots_d[k];
         end
      end
   end

   assign in_ready          = (state_q == S_FILL);
   assign mem_we            = (state_q == S_WRITE);
   assign busy              = (state_q != S_IDLE);
   assign done              = (state_q == S_DONE);
   assign mem_write_address = addr_q;
   assign mem_select        = sel_q;
   assign mem_in            = data_q;

endmodule

// File: tb/tb_kernel_mem_loader.sv
// Randomized bench for kernel_mem_loader checked against a
// per-kernel/half-block reference model of expected memory writes.
module tb_kernel_mem_loader;

   localparam int D = 9;

   logic           clk;
   logic           reset;
   logic           start;
   logic [D-1:0]   base_addr;
   logic [D-1:0]   num_kernels;
   logic           in_valid;
   logic [21:0]    in_data;
   logic           in_ready;
   logic           mem_we;
   logic [D-1:0]   mem_write_address;
   logic           mem_select;
   logic [175:0]   mem_in;
   logic           busy;
   logic           done;

   kernel_mem_loader #(.KERNEL_MEM_DEPTH_BITS(D)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .base_addr(base_addr),
      .num_kernels(num_kernels),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .mem_we(mem_we),
      .mem_write_address(mem_write_address),
      .mem_select(mem_select),
      .mem_in(mem_in),
      .busy(busy),
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int chk = 0;
   int pass = 0;

   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int rdy_viol = 0;

   logic [21:0]  elems [$];
   logic [D-1:0] wa [$];
   logic         ws [$];
   logic [175:0] wd [$];
   int           wc [$];
   logic [D-1:0] exp_a [$];
   logic         exp_s [$];
   logic [175:0] exp_d [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (mem_we === 1'b1) begin
            wa.push_back(mem_write_address);
            ws.push_back(mem_select);
            wd.push_back(mem_in);
            wc.push_back(cyc);
         end
         if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
         end
         // Ready must be low exactly in the write cycles of a load.
         if (busy === 1'b1 && done === 1'b0 && in_ready !== !mem_we)
            rdy_viol = rdy_viol + 1;
         if (busy === 1'b0 && (in_ready !== 1'b0 || mem_we !== 1'b0))
            rdy_viol = rdy_viol + 1;
      end
   end

   task automatic clear_obs();
      wa.delete(); ws.delete(); wd.delete(); wc.delete();
      done_cnt = 0;
      rdy_viol = 0;
   endtask

   task automatic build_exp(input logic [D-1:0] b, input int n);
      exp_a.delete(); exp_s.delete(); exp_d.delete();
      for (int j = 0; j < n; j++) begin
         for (int h = 0; h < 2; h++) begin
            logic [175:0] w;
            w = '0;
            for (int k = 0; k < 8; k++)
               w[22*k +: 22] = elems[16*j + 8*h + k];
            exp_a.push_back(D'((int'(b) + j) % (1 << D)));
            exp_s.push_back(h[0]);
            exp_d.push_back(w);
         end
      end
   endtask

   task automatic fill_elems(input int n, input bit ramp);
      elems.delete();
      for (int i = 0; i < n; i++)
         elems.push_back(ramp ? 22'(i) : 22'($urandom));
   endtask

   task automatic run_load(input logic [D-1:0] b, input logic [D-1:0] n,
                           input int gap, input int nel, input int spulse,
                           output bit tmo);
      int idx;
      int budget;
      bit v;
      bit x;
      tmo = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; num_kernels = n;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = D'($urandom);
      num_kernels = D'($urandom);
      idx = 0;
      budget = 0;
      while (idx < nel && budget < 3000) begin
         v = ($urandom_range(99) >= gap);
         in_valid = v;
         in_data = v ? elems[idx] : 22'($urandom);
         start = (budget == spulse);
         x = v && in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (x) idx++;
         budget++;
      end
      in_valid = 1'b0;
      if (idx < nel) tmo = 1'b1;
      if (nel == 16 * int'(n)) begin
         budget = 0;
         while (done !== 1'b1 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
         end
         if (done !== 1'b1) tmo = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", in_ready); else pass++;
      chk++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %b exp 0", mem_we); else pass++;
      chk++; if (mem_select !== 1'b0) $display("FAIL rst_sel got %b exp 0", mem_select); else pass++;
      chk++; if (mem_write_address !== '0) $display("FAIL rst_addr got %h exp 0", mem_write_address); else pass++;
      chk++; if (mem_in !== '0) $display("FAIL rst_mem_in got %h exp 0", mem_in); else pass++;
      chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass++;
      chk++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else pass++;
      reset = 1'b0;
      @(posedge clk); #1;
      chk++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL post_rst_idle got busy=%b rdy=%b exp 0 0", busy, in_ready); else pass++;
   endtask

   task automatic test_basic();
      bit tmo;
      clear_obs();
      fill_elems(16, 1'b1);
      build_exp(D'(5), 1);
      run_load(D'(5), D'(1), 0, 16, -1, tmo);
      chk++; if (tmo) $display("FAIL basic_timeout got 1 exp 0"); else pass++;
      chk++; if (wa.size() != 2) $display("FAIL basic_nwrites got %0d exp 2", wa.size()); else pass++;
      for (int i = 0; i < 2 && i < wa.size(); i++) begin
         chk++; if (wa[i] !== exp_a[i]) $display("FAIL basic_addr[%0d] got %0d exp %0d", i, wa[i], exp_a[i]); else pass++;
         chk++; if (ws[i] !== exp_s[i]) $display("FAIL basic_sel[%0d] got %b exp %b", i, ws[i], exp_s[i]); else pass++;
         chk++; if (wd[i] !== exp_d[i]) $display("FAIL basic_data[%0d] got %h exp %h", i, wd[i], exp_d[i]); else pass++;
      end
      if (wc.size() == 2) begin
         chk++; if (wc[1] != wc[0] + 9) $display("FAIL basic_write_spacing got %0d exp 9", wc[1] - wc[0]); else pass++;
         chk++; if (done_cyc != wc[1] + 1) $display("FAIL basic_done_cycle got %0d exp %0d", done_cyc, wc[1] + 1); else pass++;
      end
      chk++; if (done_cnt != 1) $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); else pass++;
      chk++; if (mem_write_address !== D'(5) || mem_select !== 1'b1 || mem_in !== exp_d[1])
         $display("FAIL basic_hold got addr=%0d sel=%b exp 5 1", mem_write_address, mem_select); else pass++;
   endtask

   task automatic test_wrap();
      bit tmo;
      clear_obs();
      fill_elems(48, 1'b0);
      build_exp(D'(510), 3);
      run_load(D'(510), D'(3), 0, 48, -1, tmo);
      chk++; if (tmo) $display("FAIL wrap_timeout got 1 exp 0"); else pass++;
      chk++; if (wa.size() != 6) $display("FAIL wrap_nwrites got %0d exp 6", wa.size()); else pass++;
      for (int i = 0; i < 6 && i < wa.size(); i++) begin
         chk++; if (wa[i] !== exp_a[i] || ws[i] !== exp_s[i])
            $display("FAIL wrap_addr_sel[%0d] got %0d/%b exp %0d/%b", i, wa[i], ws[i], exp_a[i], exp_s[i]); else pass++;
         chk++; if (wd[i] !== exp_d[i]) $display("FAIL wrap_data[%0d] got %h exp %h", i, wd[i], exp_d[i]); else pass++;
      end
   endtask

   task automatic test_zero();
      clear_obs();
      @(posedge clk); #1;
      start = 1'b1; base_addr = D'(33); num_kernels = '0;
      @(posedge clk); #1;
      start = 1'b0;
      chk++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL zero_done got done=%b busy=%b exp 1 1", done, busy); else pass++;
      @(posedge clk); #1;
      chk++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_idle got done=%b busy=%b exp 0 0", done, busy); else pass++;
      repeat (3) @(posedge clk);
      #1;
      chk++; if (wa.size() != 0) $display("FAIL zero_nwrites got %0d exp 0", wa.size()); else pass++;
   endtask

   task automatic test_gaps();
      bit tmo;
      logic [175:0] ref_d [$];
      logic [D-1:0] ref_a [$];
      clear_obs();
      fill_elems(32, 1'b0);
      build_exp(D'(77), 2);
      run_load(D'(77), D'(2), 0, 32, -1, tmo);
      ref_d = wd;
      ref_a = wa;
      clear_obs();
      run_load(D'(77), D'(2), 50, 32, -1, tmo);
      chk++; if (tmo) $display("FAIL gaps_timeout got 1 exp 0"); else pass++;
      chk++; if (wd.size() != 4 || ref_d.size() != 4)
         $display("FAIL gaps_nwrites got %0d/%0d exp 4", wd.size(), ref_d.size()); else pass++;
      for (int i = 0; i < 4 && i < wd.size() && i < ref_d.size(); i++) begin
         chk++; if (wd[i] !== ref_d[i] || wa[i] !== ref_a[i])
            $display("FAIL gaps_vs_nogap[%0d] got %h exp %h", i, wd[i], ref_d[i]); else pass++;
         chk++; if (wd[i] !== exp_d[i] || ws[i] !== exp_s[i] || wa[i] !== exp_a[i])
            $display("FAIL gaps_model[%0d] got %h exp %h", i, wd[i], exp_d[i]); else pass++;
      end
      chk++; if (rdy_viol != 0) $display("FAIL gaps_ready_rule got %0d violations exp 0", rdy_viol); else pass++;
   endtask

   task automatic test_reset_mid();
      bit tmo;
      clear_obs();
      fill_elems(32, 1'b0);
      run_load(D'(20), D'(2), 0, 11, -1, tmo);
      reset = 1'b1; in_valid = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      chk++; if (busy !== 1'b0 || mem_we !== 1'b0 || in_ready !== 1'b0 || mem_in !== '0)
         $display("FAIL midrst_state got busy=%b we=%b rdy=%b exp 0 0 0", busy, mem_we, in_ready); else pass++;
      reset = 1'b0; in_valid = 1'b0; start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk++; if (wa.size() != 1 || busy !== 1'b0) $display("FAIL midrst_nwrites got %0d exp 1", wa.size()); else pass++;
      clear_obs();
      fill_elems(16, 1'b0);
      build_exp(D'(7), 1);
      run_load(D'(7), D'(1), 20, 16, -1, tmo);
      chk++; if (tmo || wd.size() != 2) $display("FAIL midrst_reload_n got %0d exp 2", wd.size()); else pass++;
      for (int i = 0; i < 2 && i < wd.size(); i++) begin
         chk++; if (wd[i] !== exp_d[i] || wa[i] !== exp_a[i] || ws[i] !== exp_s[i])
            $display("FAIL midrst_reload[%0d] got %h exp %h", i, wd[i], exp_d[i]); else pass++;
      end
   endtask

   task automatic test_start_busy();
      bit tmo;
      clear_obs();
      fill_elems(32, 1'b0);
      build_exp(D'(100), 2);
      run_load(D'(100), D'(2), 0, 32, 3, tmo);
      run_load(D'(300), D'(0), 0, 0, -1, tmo);
      clear_obs();
      run_load(D'(100), D'(2), 0, 32, 8, tmo);
      chk++; if (tmo || wa.size() != 4) $display("FAIL sbusy_nwrites got %0d exp 4", wa.size()); else pass++;
      for (int i = 0; i < 4 && i < wa.size(); i++) begin
         chk++; if (wa[i] !== exp_a[i] || ws[i] !== exp_s[i] || wd[i] !== exp_d[i])
            $display("FAIL sbusy_write[%0d] got %0d/%b exp %0d/%b", i, wa[i], ws[i], exp_a[i], exp_s[i]); else pass++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk++; if (done_cnt != 1 || busy !== 1'b0) $display("FAIL sbusy_done_cnt got %0d exp 1", done_cnt); else pass++;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      base_addr = '0;
      num_kernels = '0;
      in_valid = 1'b0;
      in_data = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_zero();
      test_gaps();
      test_reset_mid();
      test_start_busy();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1);
   end

endmodule

// File: doc/kernel_mem_loader.md
KERNEL_MEM_LOADER -- requirements
Module: kernel_mem_loader

Interface
REQ-001 Parameter KERNEL_MEM_DEPTH_BITS, default 9, width of the kernel memory write address.
REQ-002 clk  input  1  sole clock; all logic on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins a load; sampled only in IDLE.
REQ-005 base_addr  input  KERNEL_MEM_DEPTH_BITS  first kernel-memory row, latched on accepted start.
REQ-006 num_kernels  input  KERNEL_MEM_DEPTH_BITS  number of 4x4 kernels to load, latched on accepted start.
REQ-007 in_valid  input  1  stream element valid.
REQ-008 in_data  input  22  complex_t element: [21:11]=r, [10:0]=i.
REQ-009 in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-010 mem_we  output  1  kernel memory write enable.
REQ-011 mem_write_address  output  KERNEL_MEM_DEPTH_BITS  kernel memory write row.
REQ-012 mem_select  output  1  sub-block select: 0 = kernel rows 0-1, 1 = kernel rows 2-3.
REQ-013 mem_in  output  176  eight complex_t; slot k at bits [22k+21:22k]; slot k maps to in[k/4][k%4].
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a load completes.

Function
REQ-016 States: IDLE, FILL, WRITE, DONE.
REQ-017 IDLE: in_ready=0; start with num_kernels!=0 -> FILL, clearing slot counter, half bit, kernel counter; start with num_kernels=0 -> DONE with no writes.
REQ-018 FILL: in_ready=1; each transfer stores in_data into slot (slot counter) and increments the 3-bit slot counter; transfer into slot 7 -> WRITE.
REQ-019 Kernel elements arrive in row-major order, 16 per kernel: elements 0-7 form half 0, elements 8-15 form half 1.
REQ-020 WRITE: exactly one cycle; mem_we=1, mem_select=half bit, mem_write_address=(base_addr+kernel counter) mod 2^KERNEL_MEM_DEPTH_BITS, mem_in = the eight stored slots; in_ready=0.
REQ-021 WRITE exit: half=0 -> half=1, FILL; half=1 and kernel counter=num_kernels-1 -> DONE; otherwise half=0, kernel counter+1, FILL.
REQ-022 Latency: slot-7 transfer at cycle t -> mem_we high at t+1 -> in_ready high again at t+2; sustained throughput 8 elements per 9 cycles.
REQ-023 DONE: done=1, busy=1, in_ready=0 for one cycle, then IDLE.
REQ-024 mem_we is 0 in all states except WRITE; mem_write_address, mem_select, mem_in hold their last values outside WRITE.
REQ-025 start outside IDLE is ignored; base_addr and num_kernels changes after latching have no effect.
REQ-026 Address wrap: base_addr+kernel counter overflow wraps modulo 2^KERNEL_MEM_DEPTH_BITS with no error indication.
REQ-027 in_valid=0 in FILL stalls the slot counter; gaps of any length are allowed.

Reset
REQ-028 reset=1 at any clock edge, including mid-load, forces IDLE and clears slot counter, half bit and kernel counter; a partially filled group is discarded with no write.
REQ-029 Values during and after reset: in_ready=0, mem_we=0, mem_select=0, mem_write_address=0, mem_in=0, busy=0, done=0.
REQ-030 reset has priority over start and in_valid in the same cycle.

Verification
REQ-031 base_addr=5, num_kernels=1, 16 back-to-back elements value k -> two writes at addr 5, select 0 (slots 0-7) then select 1 (slots 8-15); done one cycle after second write.
REQ-032 base_addr=510, num_kernels=3 -> six writes at addresses 510,510,511,511,0,0 with select 0,1 alternating.
REQ-033 num_kernels=0, start -> done pulses next cycle, mem_we never asserted.
REQ-034 Random in_valid gaps (~50%) over num_kernels=2 -> mem_in contents and order identical to gap-free run; in_ready low exactly in WRITE cycles.
REQ-035 reset asserted after 11 elements of a load -> no further mem_we, busy=0 next cycle; new start loads correctly from slot 0.
REQ-036 start pulsed while busy -> ignored; write count and addresses unchanged.
